// File: rtl/ad9361_rx_deframer.sv
// ad9361_rx_deframer: AD9361 dual-port CMOS RX deframer with half-beat slip recovery, lock tracking and I/Q lane output.
// Optional feature macro AD9361_RX_ERRCNT_EN: when defined, err_count is a saturating frame-error counter; otherwise it is tied to 0.
module ad9361_rx_deframer #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int LOCK_COUNT = 8,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  frame_a,
    input  logic                  frame_b,
    input  logic [DATA_WIDTH-1:0] p0_a,
    input  logic [DATA_WIDTH-1:0] p0_b,
    input  logic [DATA_WIDTH-1:0] p1_a,
    input  logic [DATA_WIDTH-1:0] p1_b,
    input  logic                  cfg_2r,
    output logic                  valid_0,
    output logic                  valid_1,
    output logic [OUT_WIDTH-1:0]  data_i0,
    output logic [OUT_WIDTH-1:0]  data_q0,
    output logic [OUT_WIDTH-1:0]  data_i1,
    output logic [OUT_WIDTH-1:0]  data_q1,
    output logic                  locked,
    output logic                  frame_err,
    output logic [ERR_WIDTH-1:0]  err_count
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;
    state_t state;
    logic phase, cfg_q, s1_v, s1_fa, s1_fb, h_v;
    logic [DATA_WIDTH-1:0] s1_p0a, s1_p0b, s1_p1a, s1_p1b, h_p0, h_p1, x0, x1, y0, y1;
    logic [RW-1:0] run, run_inc;
    logic is10, is01, hit, cont, srch_lock, lock_now, out_ph, mode_chg, err_ev;
    // Alignment check on the registered beat; phase 1 pairs the held b-half with the current a-half
    always_comb begin
        is10      = s1_fa & ~s1_fb;
        is01      = ~s1_fa & s1_fb;
        hit       = phase ? (is01 & h_v) : is10;
        cont      = (state != SEARCH) & hit;
        run_inc   = run + 1'b1;
        srch_lock = (LOCK_COUNT == 1) & (state != LOCKED) & (is10 | (is01 & h_v));
        lock_now  = cont ? ((state == LOCKED) | (run_inc >= RW'(LOCK_COUNT))) : srch_lock;
        out_ph    = cont ? phase : is01;
        x0        = out_ph ? h_p0 : s1_p0a;
        x1        = out_ph ? h_p1 : s1_p1a;
        y0        = out_ph ? s1_p0a : s1_p0b;
        y1        = out_ph ? s1_p1a : s1_p1b;
        mode_chg  = (cfg_2r != cfg_q) & (state != SEARCH);
        err_ev    = ~mode_chg & s1_v & (state == LOCKED) & ~hit;
    end
    // Beat register, held half, alignment FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            phase <= 1'b0;
            run <= '0;
            cfg_q <= 1'b0;
            s1_v <= 1'b0;
            s1_fa <= 1'b0;
            s1_fb <= 1'b0;
            s1_p0a <= '0;
            s1_p0b <= '0;
            s1_p1a <= '0;
            s1_p1b <= '0;
            h_v <= 1'b0;
            h_p0 <= '0;
            h_p1 <= '0;
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            locked <= 1'b0;
            frame_err <= 1'b0;
            data_i0 <= '0;
            data_q0 <= '0;
            data_i1 <= '0;
            data_q1 <= '0;
        end else begin
            cfg_q <= cfg_2r;
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            frame_err <= 1'b0;
            s1_v <= in_valid;
            if (in_valid) begin
                s1_fa <= frame_a;
                s1_fb <= frame_b;
                s1_p0a <= p0_a;
                s1_p0b <= p0_b;
                s1_p1a <= p1_a;
                s1_p1b <= p1_b;
            end
            if (s1_v) begin
                h_v <= 1'b1;
                h_p0 <= s1_p0b;
                h_p1 <= s1_p1b;
            end
            if (mode_chg) begin
                state <= SEARCH;
                run <= '0;
                locked <= 1'b0;
            end else if (s1_v) begin
                if (err_ev) begin
                    state <= SEARCH;
                    run <= '0;
                    locked <= 1'b0;
                    frame_err <= 1'b1;
                end else if (cont | is10 | is01) begin
                    if (!cont) phase <= is01;
                    run <= cont ? ((state == LOCKED) ? run : run_inc) : RW'(1);
                    state <= lock_now ? LOCKED : LOCKING;
                    locked <= lock_now;
                    valid_0 <= lock_now;
                    valid_1 <= lock_now;
                    if (lock_now) begin
                        data_i0 <= OUT_WIDTH'($signed(x0));
                        data_q0 <= OUT_WIDTH'($signed(x1));
                        data_i1 <= OUT_WIDTH'($signed(y0));
                        data_q1 <= OUT_WIDTH'($signed(y1));
                    end
                end else begin
                    state <= SEARCH;
                    run <= '0;
                end
            end
        end
    end
`ifdef AD9361_RX_ERRCNT_EN
    // Saturating count of loss-of-alignment events
    always_ff @(posedge clk) begin
        if (rst) err_count <= '0;
        else if (err_ev && !(&err_count)) err_count <= err_count + 1'b1;
    end
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_ad9361_rx_deframer.sv
// tb_ad9361_rx_deframer: directed scoreboard bench for ad9361_rx_deframer.
module tb_ad9361_rx_deframer;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, frame_a = 1'b0, frame_b = 1'b0, cfg_2r = 1'b0;
    logic [11:0] p0_a = '0, p0_b = '0, p1_a = '0, p1_b = '0;
    logic valid_0, valid_1, locked, frame_err;
    logic [15:0] data_i0, data_q0, data_i1, data_q1;
    logic [7:0] err_count;
    typedef struct {
        logic [15:0] i0, q0, i1, q1;
        int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t em;
    int checks = 0, errors = 0, cyc = 0, fe_cnt = 0, exp_fe = 0, exp_err = 0;
    logic [11:0] prev_b0 = '0, prev_b1 = '0;
`ifdef AD9361_RX_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    ad9361_rx_deframer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_a(frame_a), .frame_b(frame_b),
        .p0_a(p0_a), .p0_b(p0_b), .p1_a(p1_a), .p1_b(p1_b), .cfg_2r(cfg_2r),
        .valid_0(valid_0), .valid_1(valid_1), .data_i0(data_i0), .data_q0(data_q0),
        .data_i1(data_i1), .data_q1(data_q1), .locked(locked), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sx(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic beat(input logic fa, input logic fb, input logic [11:0] a0, input logic [11:0] b0,
                        input logic [11:0] a1, input logic [11:0] b1, input bit ph, input bit emit);
        exp_t e;
        in_valid = 1'b1;
        frame_a = fa;
        frame_b = fb;
        p0_a = a0;
        p0_b = b0;
        p1_a = a1;
        p1_b = b1;
        @(posedge clk);
        #1;
        if (ph) e = '{sx(prev_b0), sx(prev_b1), sx(a0), sx(a1), cyc + 1};
        else e = '{sx(a0), sx(a1), sx(b0), sx(b1), cyc + 1};
        if (emit) sb.push_back(e);
        prev_b0 = b0;
        prev_b1 = b1;
        in_valid = 1'b0;
    endtask

    task automatic rbeat(input logic fa, input logic fb, input bit ph, input bit emit);
        beat(fa, fb, 12'($urandom()), 12'($urandom()), 12'($urandom()), 12'($urandom()), ph, emit);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every output beat must match the oldest pending expectation, at its expected cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (valid_0 || valid_1) begin
                chk("out_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    em = sb.pop_front();
                    chk("valid_0", valid_0, 1);
                    chk("valid_1", valid_1, 1);
                    chk("data_i0", data_i0, em.i0);
                    chk("data_q0", data_q0, em.q0);
                    chk("data_i1", data_i1, em.i1);
                    chk("data_q1", data_q1, em.q1);
                    chk("latency", cyc, em.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        chk("rst_locked", locked, 0);
        chk("rst_valid", valid_0, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_data_i0", data_i0, 0);
        chk("rst_data_q1", data_q1, 0);
        cfg_2r = 1'b1;
        rst = 1'b0;
        // 2R aligned lock, phase 0
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 1'b0, 12'h7FF, 12'h800, 12'(i), 12'(100 + i), 1'b0, i >= 7);
            if (i == 7) chk("lock_before_out", locked, 0);
            if (i == 8) chk("lock_at_8th", locked, 1);
        end
        idle(2);
        chk("aligned_i0", data_i0, 16'h07FF);
        chk("aligned_i1", data_i1, 16'hF800);
        chk("aligned_locked", locked, 1);
        chk("aligned_drain", sb.size(), 0);
        // Single bad beat while locked, then relock
        rbeat(1'b1, 1'b1, 1'b0, 1'b0);
        chk("err_locked_hold", locked, 1);
        rbeat(1'b1, 1'b0, 1'b0, 1'b0);
        exp_fe++;
        exp_err++;
        chk("err_pulse", frame_err, 1);
        chk("err_count_1", err_count, ERRCNT ? exp_err : 0);
        chk("err_unlocked", locked, 0);
        rbeat(1'b1, 1'b0, 1'b0, 1'b0);
        chk("err_pulse_end", frame_err, 0);
        for (int i = 0; i < 6; i++) rbeat(1'b1, 1'b0, 1'b0, i == 5);
        idle(2);
        chk("relock", locked, 1);
        chk("fe_count_1", fe_cnt, exp_fe);
        // Mid-operation reset while locked with a beat in flight
        rbeat(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        chk("mrst_valid", valid_0, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_err_count", err_count, 0);
        chk("mrst_i0", data_i0, 0);
        chk("mrst_q0", data_q0, 0);
        chk("mrst_i1", data_i1, 0);
        chk("mrst_q1", data_q1, 0);
        rst = 1'b0;
        exp_err = 0;
        idle(2);
        // Half-beat slip, phase 1
        for (int i = 0; i < 10; i++) rbeat(1'b0, 1'b1, 1'b1, i >= 7);
        idle(2);
        chk("slip_locked", locked, 1);
        chk("slip_drain", sb.size(), 0);
        // Mode change to 1R drops lock without an error
        cfg_2r = 1'b0;
        idle(1);
        chk("mode_1r_unlock", locked, 0);
        chk("mode_1r_no_err", frame_err, 0);
        for (int i = 0; i < 10; i++) rbeat(1'b1, 1'b0, 1'b0, i >= 7);
        idle(2);
        chk("r1_locked", locked, 1);
        cfg_2r = 1'b1;
        idle(1);
        chk("mode_2r_unlock", locked, 0);
        chk("mode_2r_no_err", frame_err, 0);
        idle(1);
        chk("mode_fe_count", fe_cnt, exp_fe);
        // Lock with gaps in in_valid
        for (int i = 0; i < 10; i++) begin
            rbeat(1'b1, 1'b0, 1'b0, i >= 7);
            idle(1);
        end
        idle(1);
        chk("gap_locked", locked, 1);
        chk("gap_drain", sb.size(), 0);
        // Repeated errors drive the counter into saturation
        for (int k = 0; k < 256; k++) begin
            rbeat(1'b1, 1'b1, 1'b0, 1'b0);
            exp_fe++;
            if (exp_err < 255) exp_err++;
            for (int j = 0; j < 8; j++) rbeat(1'b1, 1'b0, 1'b0, j == 7);
        end
        idle(2);
        chk("sat_err_count", err_count, ERRCNT ? exp_err : 0);
        chk("sat_fe_count", fe_cnt, exp_fe);
        chk("sat_locked", locked, 1);
        chk("final_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
